inst_fetch: RTL and testbench

//  Producer side of the instruction queue. Holds the fetch PC and issues one-word

---
 rtl/inst_fetch.sv | 136 +++++++++++++
 tb/tb_inst_fetch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch producer: holds the fetch PC, issues single-word fetches to the
// memory controller and pushes returned words (with their PC) into the instruction
// queue. Queue occupancy is tracked with a credit counter because the queue has no
// full flag. ROB and branch-predictor redirects reload the PC and discard any fetch
// that is still in flight.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no fetch outstanding; issue one when a queue slot is free
//   REQ   | fetch outstanding; its data will be pushed into the queue
//   DROP  | fetch outstanding but made stale by a redirect; data discarded
module inst_fetch #(
    parameter int AddressWidth = 32,
    parameter int IDWidth      = 32,
    parameter int QueueCount   = 8,
    parameter int CountWidth   = 4,
    parameter logic [AddressWidth-1:0] ResetPC = '0
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    output logic                    if_mc_en_out,
    output logic [AddressWidth-1:0] if_mc_addr_out,
    input  logic                    mc_if_rdy_in,
    input  logic [IDWidth-1:0]      mc_if_data_in,
    output logic                    if_instqueue_en_out,
    output logic [IDWidth-1:0]      if_instqueue_inst_out,
    output logic [AddressWidth-1:0] if_instqueue_pc_out,
    input  logic                    instqueue_if_pop_in,
    input  logic                    rob_if_rst_in,
    input  logic [AddressWidth-1:0] rob_if_pc_in,
    input  logic                    bp_if_rst_in,
    input  logic [AddressWidth-1:0] bp_if_pc_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [CountWidth:0] QueueLimit = (CountWidth+1)'(QueueCount);
    localparam logic [CountWidth:0] CreditOne  = (CountWidth+1)'(1);
    localparam logic [AddressWidth-1:0] WordMask = ~AddressWidth'(3);
    localparam logic [AddressWidth-1:0] PcStep   = AddressWidth'(4);

    state_t                  state;
    logic [AddressWidth-1:0] pc;
    logic [CountWidth-1:0]   credits;

    logic                    redirect;
    logic [AddressWidth-1:0] redirect_pc;
    logic [CountWidth:0]     credit_load;
    logic [CountWidth:0]     credit_sum;
    logic [CountWidth-1:0]   credits_next;
    logic                    can_issue;

    // Redirect selection and credit bookkeeping; a push still on the strobe
    // this cycle is counted so an outstanding fetch always owns a queue slot.
    always_comb begin
        redirect    = rob_if_rst_in | bp_if_rst_in;
        redirect_pc = (rob_if_rst_in ? rob_if_pc_in : bp_if_pc_in) & WordMask;

        credit_load = {1'b0, credits} + {{CountWidth{1'b0}}, if_instqueue_en_out};
        can_issue   = (credit_load < QueueLimit);

        credit_sum = credit_load;
        if (instqueue_if_pop_in && (credit_sum != '0)) begin
            credit_sum = credit_sum - CreditOne;
        end
        if (credit_sum > QueueLimit) begin
            credit_sum = QueueLimit;
        end
        credits_next = credit_sum[CountWidth-1:0];
    end

    // Fetch FSM with registered strobes, PC and credit counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                 <= IDLE;
            pc                    <= ResetPC;
            credits               <= '0;
            if_mc_en_out          <= 1'b0;
            if_mc_addr_out        <= '0;
            if_instqueue_en_out   <= 1'b0;
            if_instqueue_inst_out <= '0;
            if_instqueue_pc_out   <= '0;
        end else if (!rdy_in) begin
            // Stalled: nothing is sampled, but strobes must not repeat.
            if_mc_en_out        <= 1'b0;
            if_instqueue_en_out <= 1'b0;
        end else begin
            if_mc_en_out        <= 1'b0;
            if_instqueue_en_out <= 1'b0;
            credits             <= credits_next;

            if (redirect) begin
                // The queue flushes itself on the same signals, so all credits return.
                pc      <= redirect_pc;
                credits <= '0;
                case (state)
                    IDLE:    state <= IDLE;
                    REQ:     state <= mc_if_rdy_in ? IDLE : DROP;
                    DROP:    state <= mc_if_rdy_in ? IDLE : DROP;
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (can_issue) begin
                            if_mc_en_out   <= 1'b1;
                            if_mc_addr_out <= pc;
                            state          <= REQ;
                        end
                    end
                    REQ: begin
                        if (mc_if_rdy_in) begin
                            if_instqueue_en_out   <= 1'b1;
                            if_instqueue_inst_out <= mc_if_data_in;
                            if_instqueue_pc_out   <= pc;
                            pc                    <= pc + PcStep;
                            state                 <= IDLE;
                        end
                    end
                    DROP: begin
                        if (mc_if_rdy_in) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a latency-configurable memory model feeds
// responses and records the expected pushes; a monitor pops and compares them.
module tb_inst_fetch;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        if_mc_en_out;
    logic [31:0] if_mc_addr_out;
    logic        mc_if_rdy_in;
    logic [31:0] mc_if_data_in;
    logic        if_instqueue_en_out;
    logic [31:0] if_instqueue_inst_out;
    logic [31:0] if_instqueue_pc_out;
    logic        instqueue_if_pop_in;
    logic        rob_if_rst_in;
    logic [31:0] rob_if_pc_in;
    logic        bp_if_rst_in;
    logic [31:0] bp_if_pc_in;

    inst_fetch dut (
        .clk_in                (clk_in),
        .rst_n_in              (rst_n_in),
        .rdy_in                (rdy_in),
        .if_mc_en_out          (if_mc_en_out),
        .if_mc_addr_out        (if_mc_addr_out),
        .mc_if_rdy_in          (mc_if_rdy_in),
        .mc_if_data_in         (mc_if_data_in),
        .if_instqueue_en_out   (if_instqueue_en_out),
        .if_instqueue_inst_out (if_instqueue_inst_out),
        .if_instqueue_pc_out   (if_instqueue_pc_out),
        .instqueue_if_pop_in   (instqueue_if_pop_in),
        .rob_if_rst_in         (rob_if_rst_in),
        .rob_if_pc_in          (rob_if_pc_in),
        .bp_if_rst_in          (bp_if_rst_in),
        .bp_if_pc_in           (bp_if_pc_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } push_t;

    int          checks   = 0;
    int          failures = 0;
    push_t       exp_q[$];
    logic [31:0] req_q[$];
    int          n_push    = 0;
    int          lat       = 2;
    bit          drop_resp = 1'b0;
    bit          resp_pend = 1'b0;
    int          resp_cnt  = 0;
    logic [31:0] resp_addr = '0;
    bit          mon_on    = 1'b0;
    bit          prev_push = 1'b0;
    bit          prev_req  = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Scoreboard side: every push must match the oldest expected word; strobes are single-cycle.
    always @(negedge clk_in) begin
        push_t e;
        if (mon_on && rst_n_in) begin
            if (prev_push) begin
                checks++;
                if (if_instqueue_en_out !== 1'b0) begin
                    failures++;
                    $display("FAIL push_strobe_width en=%b required 0", if_instqueue_en_out);
                end
            end
            if (prev_req) begin
                checks++;
                if (if_mc_en_out !== 1'b0) begin
                    failures++;
                    $display("FAIL req_strobe_width en=%b required 0", if_mc_en_out);
                end
            end
            if (if_instqueue_en_out === 1'b1) begin
                n_push++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL push_unexpected pc=%h inst=%h required no push",
                             if_instqueue_pc_out, if_instqueue_inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (if_instqueue_pc_out !== e.pc || if_instqueue_inst_out !== e.inst) begin
                        failures++;
                        $display("FAIL push_data pc=%h inst=%h required pc=%h inst=%h",
                                 if_instqueue_pc_out, if_instqueue_inst_out, e.pc, e.inst);
                    end
                end
            end
        end
        prev_push = mon_on && rst_n_in && (if_instqueue_en_out === 1'b1);
        prev_req  = mon_on && rst_n_in && (if_mc_en_out === 1'b1);
    end

    // One clock of the memory model; all bench inputs are driven from this process.
    task automatic cycle();
        @(negedge clk_in);
        #1;
        mc_if_rdy_in = 1'b0;
        if (resp_pend) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                resp_pend     = 1'b0;
                mc_if_rdy_in  = 1'b1;
                mc_if_data_in = word_of(resp_addr);
                if (drop_resp) drop_resp = 1'b0;
                else exp_q.push_back({resp_addr, word_of(resp_addr)});
            end
        end
        if (if_mc_en_out === 1'b1) begin
            req_q.push_back(if_mc_addr_out);
            resp_pend = 1'b1;
            resp_cnt  = lat;
            resp_addr = if_mc_addr_out;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_req(input int n, input int budget, output bit ok);
        int t = 0;
        while (req_q.size() < n && t < budget) begin
            cycle();
            t++;
        end
        ok = (req_q.size() >= n);
    endtask

    task automatic pop_once();
        instqueue_if_pop_in = 1'b1;
        cycle();
        instqueue_if_pop_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; mc_if_rdy_in = 1'b0; mc_if_data_in = '0;
        instqueue_if_pop_in = 1'b0; rob_if_rst_in = 1'b0; rob_if_pc_in = '0;
        bp_if_rst_in = 1'b0; bp_if_pc_in = '0;
        run(3);
        checks++;
        if ({if_mc_en_out, if_instqueue_en_out} !== 2'b00) begin
            failures++;
            $display("FAIL reset_strobes got=%b required 00", {if_mc_en_out, if_instqueue_en_out});
        end
        checks++;
        if (if_mc_addr_out !== 32'h0 || if_instqueue_pc_out !== 32'h0 || if_instqueue_inst_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_data addr=%h pc=%h inst=%h required 0",
                     if_mc_addr_out, if_instqueue_pc_out, if_instqueue_inst_out);
        end
        rst_n_in = 1'b1;
        mon_on   = 1'b1;
    endtask

    task automatic test_sequential_fetch();
        bit ok;
        lat = 2;
        run_until_req(3, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL seq_timeout reqs=%0d required 3", req_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (req_q[i] !== 32'(i * 4)) begin
                    failures++;
                    $display("FAIL seq_addr%0d got=%h required %h", i, req_q[i], 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_credit_limit();
        bit ok;
        run(80);
        checks++;
        if (req_q.size() != 8 || n_push != 8) begin
            failures++;
            $display("FAIL credit_fill reqs=%0d pushes=%0d required 8/8", req_q.size(), n_push);
        end
        for (int i = 3; i < req_q.size() && i < 8; i++) begin
            checks++;
            if (req_q[i] !== 32'(i * 4)) begin
                failures++;
                $display("FAIL fill_addr%0d got=%h required %h", i, req_q[i], 32'(i * 4));
            end
        end
        pop_once();
        run_until_req(9, 10, ok);
        checks++;
        if (!ok || req_q[8] !== 32'h20) begin
            failures++;
            $display("FAIL pop_req ok=%0d addr=%h required 1/00000020", ok, ok ? req_q[8] : 32'hx);
        end
        run(20);
        checks++;
        if (req_q.size() != 9 || n_push != 9) begin
            failures++;
            $display("FAIL pop_one_more reqs=%0d pushes=%0d required 9/9", req_q.size(), n_push);
        end
    endtask

    task automatic test_rob_redirect_in_req();
        bit ok;
        int base;
        req_q.delete();
        base = n_push;
        lat  = 4;
        pop_once();
        run_until_req(1, 10, ok);
        checks++;
        if (!ok || req_q[0] !== 32'h24) begin
            failures++;
            $display("FAIL rob_pre_req ok=%0d required request to 00000024", ok);
        end
        rob_if_rst_in = 1'b1; rob_if_pc_in = 32'h1002; drop_resp = 1'b1;
        cycle();
        rob_if_rst_in = 1'b0;
        run_until_req(2, 20, ok);
        checks++;
        if (!ok || req_q[1] !== 32'h1000) begin
            failures++;
            $display("FAIL rob_target ok=%0d addr=%h required 00001000", ok, ok ? req_q[1] : 32'hx);
        end
        lat = 1;
        run(80);
        checks++;
        if (n_push - base != 8 || req_q.size() != 9) begin
            failures++;
            $display("FAIL rob_credits pushes=%0d reqs=%0d required 8/9", n_push - base, req_q.size());
        end
    endtask

    task automatic test_rob_over_bp();
        bit ok;
        int base;
        req_q.delete();
        base = n_push;
        rob_if_rst_in = 1'b1; rob_if_pc_in = 32'h200;
        bp_if_rst_in  = 1'b1; bp_if_pc_in  = 32'h300;
        cycle();
        rob_if_rst_in = 1'b0; bp_if_rst_in = 1'b0;
        run_until_req(1, 10, ok);
        checks++;
        if (!ok || req_q[0] !== 32'h200) begin
            failures++;
            $display("FAIL rob_priority ok=%0d addr=%h required 00000200", ok, ok ? req_q[0] : 32'hx);
        end
        run(60);
        checks++;
        if (n_push - base != 8) begin
            failures++;
            $display("FAIL prio_refill pushes=%0d required 8", n_push - base);
        end
    endtask

    task automatic test_redirect_with_response();
        bit ok;
        int t;
        int base;
        req_q.delete();
        lat = 3;
        pop_once();
        run_until_req(1, 10, ok);
        checks++;
        if (!ok || req_q[0] !== 32'h220) begin
            failures++;
            $display("FAIL same_pre_req ok=%0d required request to 00000220", ok);
        end
        drop_resp = 1'b1;
        t = 0;
        while (mc_if_rdy_in !== 1'b1 && t < 10) begin
            cycle();
            t++;
        end
        bp_if_rst_in = 1'b1; bp_if_pc_in = 32'h4000;
        base = n_push;
        cycle();
        bp_if_rst_in = 1'b0;
        run_until_req(2, 3, ok);
        checks++;
        if (!ok || req_q[1] !== 32'h4000) begin
            failures++;
            $display("FAIL same_cycle_target ok=%0d addr=%h required 00004000 within 3 cycles",
                     ok, ok ? req_q[1] : 32'hx);
        end
        lat = 1;
        run(60);
        checks++;
        if (n_push - base != 8) begin
            failures++;
            $display("FAIL same_cycle_refill pushes=%0d required 8", n_push - base);
        end
    endtask

    task automatic test_stall_and_async_reset();
        bit ok;
        int base;
        req_q.delete();
        base = n_push;
        lat  = 6;
        pop_once();
        run_until_req(1, 10, ok);
        checks++;
        if (!ok || req_q[0] !== 32'h4020) begin
            failures++;
            $display("FAIL stall_pre_req ok=%0d required request to 00004020", ok);
        end
        rdy_in = 1'b0; bp_if_rst_in = 1'b1; bp_if_pc_in = 32'h7000; instqueue_if_pop_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({if_mc_en_out, if_instqueue_en_out} !== 2'b00) begin
                failures++;
                $display("FAIL stall_strobes got=%b required 00", {if_mc_en_out, if_instqueue_en_out});
            end
        end
        rdy_in = 1'b1; bp_if_rst_in = 1'b0; instqueue_if_pop_in = 1'b0;
        run(20);
        checks++;
        if (n_push - base != 1 || req_q.size() != 1) begin
            failures++;
            $display("FAIL stall_resume pushes=%0d reqs=%0d required 1/1", n_push - base, req_q.size());
        end
        lat = 30;
        pop_once();
        run_until_req(2, 10, ok);
        checks++;
        if (!ok || req_q[1] !== 32'h4024) begin
            failures++;
            $display("FAIL reset_pre_req ok=%0d required request to 00004024", ok);
        end
        cycle();
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({if_mc_en_out, if_instqueue_en_out} !== 2'b00 || if_mc_addr_out !== 32'h0 ||
            if_instqueue_pc_out !== 32'h0 || if_instqueue_inst_out !== 32'h0) begin
            failures++;
            $display("FAIL async_reset en=%b addr=%h pc=%h inst=%h required all 0",
                     {if_mc_en_out, if_instqueue_en_out}, if_mc_addr_out,
                     if_instqueue_pc_out, if_instqueue_inst_out);
        end
        resp_pend = 1'b0; drop_resp = 1'b0;
        exp_q.delete(); req_q.delete();
        run(2);
        rst_n_in = 1'b1;
        lat = 1;
        run_until_req(1, 10, ok);
        checks++;
        if (!ok || req_q[0] !== 32'h0) begin
            failures++;
            $display("FAIL restart_pc ok=%0d addr=%h required 00000000", ok, ok ? req_q[0] : 32'hx);
        end
        run(5);
    endtask

    initial begin
        test_reset();
        test_sequential_fetch();
        test_credit_limit();
        test_rob_redirect_in_req();
        test_rob_over_bp();
        test_redirect_with_response();
        test_stall_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
